// File: rtl/gray_ticket_arb.sv
// gray_ticket_arb: round-robin arbiter that hands each winner a gray-coded
// ticket from one shared sequence counter, then advances the counter.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   en       arbitration enable (0: no grants, requests stay pending)
//   clr      synchronous clear of counter and priority pointer
//   req      per-requester request, held until granted
//   gnt      registered one-hot grant pulse
//   gnt_vld  registered, equals |gnt
//   ticket   gray ticket of the current grant (holds between grants)
//   wrap     pulses with the grant carrying the last code before wrap-around
module gray_ticket_arb #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CBITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic             gnt_vld,
  output logic [CBITS-1:0] ticket,
  output logic             wrap
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [CBITS-1:0] ticket_q, ticket_d;
  logic             wrap_q, wrap_d;

  logic             found_c;
  logic [PW-1:0]    win_c;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + i) % NREQ;
      if (!found_c && req[PW'(idx)]) begin
        found_c = 1'b1;
        win_c   = PW'(idx);
      end
    end
  end

  // Next-state: clr dominates, then en gates any grant.
  always_comb begin
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    gnt_vld_d = 1'b0;
    ticket_d  = ticket_q;
    wrap_d    = 1'b0;
    if (clr) begin
      cnt_d    = '0;
      ptr_d    = PW'(NREQ - 1);
      ticket_d = '0;
    end else if (en && found_c) begin
      gnt_d     = NREQ'(1) << win_c;
      gnt_vld_d = 1'b1;
      ticket_d  = cnt_q ^ (cnt_q >> 1);
      wrap_d    = (cnt_q == {CBITS{1'b1}});
      cnt_d     = cnt_q + CBITS'(1);
      ptr_d     = win_c;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      ptr_q     <= PW'(NREQ - 1);
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      ticket_q  <= '0;
      wrap_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      ticket_q  <= ticket_d;
      wrap_q    <= wrap_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign ticket  = ticket_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_gray_ticket_arb.sv
// Directed bench for gray_ticket_arb: a 4x10 instance for arbitration,
// clear, enable and reset behaviour, and a 4x3 instance for wrap-around.
module tb_gray_ticket_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic [3:0] req;
  logic [3:0] req2;

  logic [3:0] gnt,  gnt2;
  logic       vld,  vld2;
  logic [9:0] tkt;
  logic [2:0] tkt2;
  logic       wrap, wrap2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_ticket_arb #(.NREQ(4), .CBITS(10)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req),
    .gnt(gnt), .gnt_vld(vld), .ticket(tkt), .wrap(wrap)
  );

  gray_ticket_arb #(.NREQ(4), .CBITS(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req2),
    .gnt(gnt2), .gnt_vld(vld2), .ticket(tkt2), .wrap(wrap2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the full output set of the 10-bit instance.
  task automatic chk_out(input string tag, input logic [3:0] eg, input logic [9:0] et,
                         input logic ew);
    chk({tag, ".gnt"},    32'(gnt),  32'(eg));
    chk({tag, ".vld"},    32'(vld),  32'(eg != 4'b0));
    chk({tag, ".ticket"}, 32'(tkt),  32'(et));
    chk({tag, ".wrap"},   32'(wrap), 32'(ew));
  endtask

  // Advance one clock; outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fair_g [5];
  logic [9:0] fair_t [5];
  logic [2:0] wrap_t [9];

  initial begin
    fair_g[0] = 4'b0001; fair_g[1] = 4'b0010; fair_g[2] = 4'b0100;
    fair_g[3] = 4'b1000; fair_g[4] = 4'b0001;
    fair_t[0] = 10'h000; fair_t[1] = 10'h001; fair_t[2] = 10'h003;
    fair_t[3] = 10'h002; fair_t[4] = 10'h006;
    wrap_t[0] = 3'b000; wrap_t[1] = 3'b001; wrap_t[2] = 3'b011;
    wrap_t[3] = 3'b010; wrap_t[4] = 3'b110; wrap_t[5] = 3'b111;
    wrap_t[6] = 3'b101; wrap_t[7] = 3'b100; wrap_t[8] = 3'b000;

    rst = 1'b0; en = 1'b1; clr = 1'b0; req = 4'b0; req2 = 4'b0;
    #2;
    chk_out("reset", 4'b0000, 10'h000, 1'b0);
    step();
    rst = 1'b1;

    // Single request.
    req = 4'b0001;
    step();
    chk_out("single0", 4'b0001, 10'h000, 1'b0);
    req = 4'b0000;
    step();
    chk_out("idle_hold", 4'b0000, 10'h000, 1'b0);
    req = 4'b0100;
    step();
    chk_out("single2", 4'b0100, 10'h001, 1'b0);
    req = 4'b0000;

    // Clear, then fairness with all requesters held.
    clr = 1'b1;
    step();
    chk_out("clr_a", 4'b0000, 10'h000, 1'b0);
    clr = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("fair%0d", i), fair_g[i], fair_t[i], 1'b0);
    end
    req = 4'b0000;

    // Clear with pending requests: no grant that cycle, then req[1] first.
    clr = 1'b1;
    req = 4'b1010;
    step();
    chk_out("clr_b", 4'b0000, 10'h000, 1'b0);
    clr = 1'b0;
    step();
    chk_out("clr_b_next", 4'b0010, 10'h000, 1'b0);
    req = 4'b1000;
    step();
    chk_out("clr_b_next2", 4'b1000, 10'h001, 1'b0);
    req = 4'b0000;

    // Enable gating: request pends, counter frozen.
    en = 1'b0;
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("en_off%0d", i), 4'b0000, 10'h001, 1'b0);
    end
    en = 1'b1;
    step();
    chk_out("en_on", 4'b0100, 10'h003, 1'b0);
    req = 4'b0000;

    // Async reset in the middle of continuous grants.
    req = 4'b1111;
    step();
    chk_out("pre_rst0", 4'b1000, 10'h002, 1'b0);
    step();
    chk_out("pre_rst1", 4'b0001, 10'h006, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_out("async_rst", 4'b0000, 10'h000, 1'b0);
    #2;
    rst = 1'b1;
    step();
    chk_out("post_rst", 4'b0001, 10'h000, 1'b0);
    req = 4'b0000;
    step();

    // Wrap-around on the 3-bit instance.
    req2 = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("w%0d.gnt", i),    32'(gnt2),  32'(4'b0001));
      chk($sformatf("w%0d.vld", i),    32'(vld2),  32'(1'b1));
      chk($sformatf("w%0d.ticket", i), 32'(tkt2),  32'(wrap_t[i]));
      chk($sformatf("w%0d.wrap", i),   32'(wrap2), 32'(i == 7));
    end
    req2 = 4'b0000;
    step();
    chk("w_end.vld", 32'(vld2), 32'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
